// File: rtl/lm80c_pkg.sv
// Shared LM80C definitions: file-transfer FSM states and memory-map
// constants used by the PRG downloader and uploader.
package lm80c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PTR_LO,
        ST_PTR_HI,
        ST_CALC,
        ST_REQ,
        ST_WAIT_UP,
        ST_SERVE,
        ST_DONE
    } upl_state_t;

    localparam logic [7:0]  PRG_INDEX      = 8'd2;
    localparam logic [15:0] PRG_START_ADDR = 16'h5608;
    localparam logic [15:0] PTR_PROGND     = 16'h55e4;

    // Program length from the BASIC end pointer; an end at or below
    // the program start means an empty program.
    function automatic logic [15:0] calc_len(input logic [15:0] end_ptr);
        if (end_ptr > PRG_START_ADDR)
            return end_ptr - PRG_START_ADDR;
        else
            return 16'h0000;
    endfunction

endpackage

// File: rtl/prg_uploader.sv
// Saves the resident BASIC program to the HPS: reads the end pointer,
// requests an upload, then serves bytes from RAM with a 2-cycle latency.
module prg_uploader
    import lm80c_pkg::*;
(
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        trigger,
    input  logic        ioctl_upload,
    input  logic [7:0]  ioctl_index,
    input  logic [24:0] ioctl_addr,
    input  logic        ioctl_rd,
    output logic [7:0]  ioctl_din,
    output logic        ioctl_upload_req,
    output logic        busy,
    output logic        done,
    output logic [15:0] prg_len,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_din
);

    upl_state_t state;
    upl_state_t state_nx;

    logic [7:0] ptr_lo;
    logic       upload_q;
    logic       pend;
    logic       pend_zero;
    logic       rd_hit;
    logic       rd_in_range;

    assign rd_hit      = (state == ST_SERVE) && ioctl_rd;
    assign rd_in_range = ioctl_addr < {9'd0, prg_len};
    assign busy        = (state != ST_IDLE);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ptr_lo    <= 8'h00;
            prg_len   <= 16'h0000;
            upload_q  <= 1'b0;
            pend      <= 1'b0;
            pend_zero <= 1'b0;
            ioctl_din <= 8'h00;
        end else begin
            upload_q <= ioctl_upload;
            if (state == ST_PTR_HI)
                ptr_lo <= mem_din;
            if (state == ST_CALC)
                prg_len <= calc_len({mem_din, ptr_lo});
            // A newer strobe supersedes a fetch still in flight.
            if (pend && !rd_hit)
                ioctl_din <= pend_zero ? 8'h00 : mem_din;
            pend <= rd_hit;
            if (rd_hit)
                pend_zero <= !rd_in_range;
        end
    end

    always_comb begin
        state_nx         = state;
        mem_rd           = 1'b0;
        mem_addr         = 16'h0000;
        ioctl_upload_req = 1'b0;
        done             = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (trigger)
                    state_nx = ST_PTR_LO;
            end
            ST_PTR_LO: begin
                mem_rd   = 1'b1;
                mem_addr = PTR_PROGND;
                state_nx = ST_PTR_HI;
            end
            ST_PTR_HI: begin
                mem_rd   = 1'b1;
                mem_addr = PTR_PROGND + 16'd1;
                state_nx = ST_CALC;
            end
            ST_CALC: begin
                state_nx = ST_REQ;
            end
            ST_REQ: begin
                ioctl_upload_req = 1'b1;
                state_nx         = ST_WAIT_UP;
            end
            ST_WAIT_UP: begin
                if (ioctl_upload && ioctl_index == PRG_INDEX)
                    state_nx = ST_SERVE;
            end
            ST_SERVE: begin
                if (rd_hit && rd_in_range) begin
                    mem_rd   = 1'b1;
                    mem_addr = PRG_START_ADDR + ioctl_addr[15:0];
                end
                if (upload_q && !ioctl_upload)
                    state_nx = ST_DONE;
            end
            ST_DONE: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule
